// File: rtl/FPU_192_Package.sv
// Shared FPU_192 datapath constants and elaboration-time helpers.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package FPU_192_Package;

    // Width of the aligned mantissa handed between alignment and normalisation.
    localparam int NORMALIZE_MANTISSA_LENGTH = 160;

    // Default number of carry-chunk register stages in the mantissa adder.
    localparam int MANT_ADD_STAGES = 4;

    // Integer ceiling division, used to size carry chunks at elaboration.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/mant_add_chunk.sv
// One carry-chunk slice of the mantissa adder: sum = a + b + cin.
// Latency: combinational.
// Backpressure: n/a; flow control is handled by the enclosing pipeline.
module mant_add_chunk #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/mantissa_addsub_pipe.sv
// Pipelined signed-magnitude mantissa add/sub, carry split over STAGES chunks plus a sign-fix stage.
// Latency: STAGES+1 cycles from acceptance to out_valid; one operation per cycle when unstalled.
// Backpressure: valid/ready per stage, bubbles collapse; in_ready is combinational on out_ready.
module mantissa_addsub_pipe
    import FPU_192_Package::*;
#(
    parameter int WIDTH  = NORMALIZE_MANTISSA_LENGTH,
    parameter int STAGES = MANT_ADD_STAGES,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] man_x,
    input  logic [WIDTH-1:0] man_y,
    input  logic             sign_x,
    input  logic             sign_y,
    input  logic             add_sub,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             sign_r,
    output logic             zero,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CHUNK = ceil_div(WIDTH, STAGES);

    // Effective operation: 1 means magnitudes are subtracted.
    logic op_in;
    assign op_in = add_sub ^ sign_x ^ sign_y;

    // Valid bits: [STAGES-1:0] are carry stages, [STAGES] is the output register.
    logic [STAGES:0] v_q;
    logic [STAGES:0] up_v;
    logic [STAGES:0] rdy;
    logic [STAGES:0] load;
    logic            tail_full;

    // Per-stage payload; operands travel whole so each op keeps its own upper bits.
    logic [WIDTH-1:0] x_q   [STAGES];
    logic [WIDTH-1:0] y_q   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic             c_q   [STAGES];
    logic             op_q  [STAGES];
    logic             sx_q  [STAGES];
    logic [TAG_W-1:0] tag_q [STAGES];

    // Upstream view of each stage, and the value it would load.
    logic [WIDTH-1:0] in_x   [STAGES];
    logic [WIDTH-1:0] in_y   [STAGES];
    logic             in_op  [STAGES];
    logic             in_sx  [STAGES];
    logic [TAG_W-1:0] in_tag [STAGES];
    logic [WIDTH-1:0] nsum   [STAGES];
    logic             ncar   [STAGES];

    // Sign-fix stage next values and output registers.
    logic [WIDTH-1:0] fin_res;
    logic             fin_cout;
    logic             fin_sign;
    logic             fin_zero;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             sign_q;
    logic             zero_q;
    logic [TAG_W-1:0] tag_out_q;

    assign up_v = {v_q[STAGES-1:0], in_valid};
    assign load = up_v & rdy;

    // A stage can take new data if it or any stage below it is empty, or the sink drains.
    always_comb begin
        rdy       = '0;
        tail_full = 1'b1;
        for (int k = 0; k <= STAGES; k++) begin
            tail_full = 1'b1;
            for (int j = k; j <= STAGES; j++) begin
                tail_full = tail_full & v_q[j];
            end
            rdy[k] = out_ready | ~tail_full;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;

        logic [WIDTH-1:0] usum;
        logic             uc;

        if (k == 0) begin : g_first
            assign in_x[k]   = man_x;
            assign in_y[k]   = man_y;
            assign in_op[k]  = op_in;
            assign in_sx[k]  = sign_x;
            assign in_tag[k] = tag_in;
            assign usum      = '0;
            assign uc        = op_in;
        end else begin : g_next
            assign in_x[k]   = x_q[k-1];
            assign in_y[k]   = y_q[k-1];
            assign in_op[k]  = op_q[k-1];
            assign in_sx[k]  = sx_q[k-1];
            assign in_tag[k] = tag_q[k-1];
            assign usum      = sum_q[k-1];
            assign uc        = c_q[k-1];
        end

        if (LO < WIDTH) begin : g_add
            localparam int HI = (((LO + CHUNK) < WIDTH) ? (LO + CHUNK) : WIDTH) - 1;
            localparam int N  = HI - LO + 1;
            localparam logic [WIDTH-1:0] MASK = ((WIDTH'(1) << N) - WIDTH'(1)) << LO;

            logic [N-1:0] s;
            logic         co;

            // Subtract is x + ~y + 1: the +1 enters as stage 0's carry-in.
            mant_add_chunk #(.N(N)) u_chunk (
                .a    (in_x[k][HI:LO]),
                .b    (in_y[k][HI:LO] ^ {N{in_op[k]}}),
                .cin  (uc),
                .sum  (s),
                .cout (co)
            );

            assign nsum[k] = (usum & ~MASK) | (WIDTH'(s) << LO);
            assign ncar[k] = co;
        end else begin : g_pass
            // Chunk rounding can leave trailing stages with no bits: they only delay.
            assign nsum[k] = usum;
            assign ncar[k] = uc;
        end
    end

    // Resolve the raw sum into a magnitude, corrected sign, carry and zero flag.
    always_comb begin
        fin_res  = sum_q[STAGES-1];
        fin_cout = 1'b0;
        fin_sign = sx_q[STAGES-1];
        if (!op_q[STAGES-1]) begin
            fin_cout = c_q[STAGES-1];
        end else if (!c_q[STAGES-1]) begin
            // No carry out of x + ~y + 1 means x < y: negate to get |x - y|.
            fin_res  = ~sum_q[STAGES-1] + WIDTH'(1);
            fin_sign = ~sx_q[STAGES-1];
        end
        fin_zero = (fin_res == '0);
        if (op_q[STAGES-1] && fin_zero) begin
            fin_sign = 1'b0;
        end
    end

    // Carry-stage payload needs no reset: it is qualified by the valid bits.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (load[k]) begin
                x_q[k]   <= in_x[k];
                y_q[k]   <= in_y[k];
                op_q[k]  <= in_op[k];
                sx_q[k]  <= in_sx[k];
                tag_q[k] <= in_tag[k];
                sum_q[k] <= nsum[k];
                c_q[k]   <= ncar[k];
            end
        end
    end

    // Valid bits advance whenever a stage is ready; output payload holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q       <= '0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            sign_q    <= 1'b0;
            zero_q    <= 1'b0;
            tag_out_q <= '0;
        end else begin
            for (int k = 0; k <= STAGES; k++) begin
                if (rdy[k]) begin
                    v_q[k] <= up_v[k];
                end
            end
            if (load[STAGES]) begin
                result_q  <= fin_res;
                cout_q    <= fin_cout;
                sign_q    <= fin_sign;
                zero_q    <= fin_zero;
                tag_out_q <= tag_q[STAGES-1];
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[STAGES];
    assign result    = result_q;
    assign cout      = cout_q;
    assign sign_r    = sign_q;
    assign zero      = zero_q;
    assign tag_out   = tag_out_q;

endmodule

// File: tb/tb_mantissa_addsub_pipe.sv
// Self-checking bench for mantissa_addsub_pipe at WIDTH=8, STAGES=2.
// Latency: expected 3 cycles per operation when unstalled.
// Backpressure: exercised with held-low and randomly toggled out_ready.
module tb_mantissa_addsub_pipe;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  man_x;
    logic [W-1:0]  man_y;
    logic          sign_x;
    logic          sign_y;
    logic          add_sub;
    logic [TW-1:0] tag_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          cout;
    logic          sign_r;
    logic          zero;
    logic [TW-1:0] tag_out;

    always #5 clk = ~clk;

    mantissa_addsub_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .man_x     (man_x),
        .man_y     (man_y),
        .sign_x    (sign_x),
        .sign_y    (sign_y),
        .add_sub   (add_sub),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .sign_r    (sign_r),
        .zero      (zero),
        .tag_out   (tag_out)
    );

    typedef struct packed {
        logic [W-1:0]  res;
        logic          co;
        logic          sg;
        logic          zr;
        logic [TW-1:0] tag;
    } exp_t;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         sx;
        logic         sy;
        logic         as;
        logic [W-1:0] res;
        logic         co;
        logic         sg;
        logic         zr;
    } vec_t;

    int            n_checks = 0;
    int            n_errors = 0;
    int            acc_cnt  = 0;
    logic [TW-1:0] next_tag = '0;
    exp_t          sb [$];
    vec_t          tbl [14];
    logic [14:0]   out_pl;
    logic [14:0]   held_pl;
    logic          held_vld = 1'b0;
    logic          rand_done = 1'b0;
    exp_t          mon_e;

    assign out_pl = {result, cout, sign_r, zero, tag_out};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: signed integer arithmetic on the signed-magnitude operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic sx, input logic sy, input logic as);
        int   vx, vy, r, mag;
        exp_t e;
        vx  = sx ? -int'(x) : int'(x);
        vy  = sy ? -int'(y) : int'(y);
        r   = as ? (vx - vy) : (vx + vy);
        mag = (r < 0) ? -r : r;
        e.tag = '0;
        e.res = mag[W-1:0];
        if ((as ^ sx ^ sy) == 1'b0) begin
            e.co = mag[W];
            e.sg = sx;
        end else begin
            e.co = 1'b0;
            e.sg = (r < 0);
        end
        e.zr = (e.res == '0);
        return e;
    endfunction

    // Offer one operation; returns one cycle after it is accepted, in_valid left high.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic sx, input logic sy, input logic as, input exp_t e);
        int   budget;
        exp_t ee;
        man_x    = x;
        man_y    = y;
        sign_x   = sx;
        sign_y   = sy;
        add_sub  = as;
        tag_in   = next_tag;
        in_valid = 1'b1;
        budget   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                ee     = e;
                ee.tag = next_tag;
                sb.push_back(ee);
                next_tag = next_tag + 1'b1;
                acc_cnt++;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            budget++;
            if (budget > 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", budget);
                break;
            end
        end
    endtask

    task automatic send_vec(input vec_t v);
        exp_t e;
        e = '{res: v.res, co: v.co, sg: v.sg, zr: v.zr, tag: '0};
        send(v.x, v.y, v.sx, v.sy, v.as, e);
    endtask

    task automatic drain(input string nm);
        int b;
        b = 0;
        while (sb.size() != 0 && b < 200) begin
            @(posedge clk); #1;
            b++;
        end
        chk(nm, 32'(sb.size()), 32'd0);
    endtask

    // Single operation into an empty pipe; counts cycles until out_valid.
    task automatic latency_run(input string nm, input vec_t v);
        int k;
        send_vec(v);
        in_valid = 1'b0;
        k = 1;
        forever begin
            @(negedge clk);
            if (out_valid || k > 20) break;
            @(posedge clk); #1;
            k++;
        end
        chk(nm, 32'(k), 32'd3);
    endtask

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (held_vld) chk("stall_hold", 32'(out_pl), 32'(held_pl));
            if (out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", out_pl);
                end else begin
                    mon_e = sb.pop_front();
                    chk("output", 32'(out_pl), 32'(mon_e));
                end
            end
        end
        held_vld = rst_n && out_valid && !out_ready;
        held_pl  = out_pl;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   seen;
        vec_t v;
        logic [W-1:0] rx, ry;
        logic rsx, rsy, ras;

        //          x      y      sx    sy    as    res    co    sg    zr
        tbl[0]  = '{8'hF0, 8'h20, 1'b0, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{8'h50, 8'h30, 1'b0, 1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{8'h30, 8'h50, 1'b0, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{8'h30, 8'h50, 1'b1, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{8'h7F, 8'h7F, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{8'hFF, 8'h01, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{8'h80, 8'h7F, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{8'h10, 8'h01, 1'b0, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        man_x     = '0;
        man_y     = '0;
        sign_x    = 1'b0;
        sign_y    = 1'b0;
        add_sub   = 1'b0;
        tag_in    = '0;

        // Reset state
        #12;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_payload", 32'(out_pl), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First-op latency, then the whole table back to back
        latency_run("latency_first", tbl[0]);
        drain("drain_first");
        for (int i = 0; i < 14; i++) send_vec(tbl[i]);
        in_valid = 1'b0;
        drain("drain_table");

        // Backpressure: out_ready low while six ops are offered back to back
        out_ready = 1'b0;
        acc_cnt   = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    rx = 8'(8'h17 * (i + 1));
                    ry = 8'(8'h29 * (6 - i));
                    send(rx, ry, 1'(i), 1'b0, 1'(i >> 1), model(rx, ry, 1'(i), 1'b0, 1'(i >> 1)));
                end
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                chk("bp_accepts", 32'(acc_cnt), 32'd3);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                @(posedge clk); #1;
                out_ready = 1'b1;
                #1;
                chk("bp_in_ready_comb", 32'(in_ready), 32'd1);
            end
        join
        drain("drain_bp");

        // Asynchronous reset with two operations in flight
        v = tbl[1];
        send_vec(v);
        send_vec(tbl[2]);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst_quiet", 32'(seen), 32'd0);
        @(posedge clk); #1;
        latency_run("latency_after_reset", tbl[13]);
        drain("drain_reset");

        // Random traffic with random output stalls
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    rx  = 8'($urandom_range(0, 255));
                    ry  = (i % 8 == 0) ? rx : 8'($urandom_range(0, 255));
                    rsx = 1'($urandom_range(0, 1));
                    rsy = 1'($urandom_range(0, 1));
                    ras = 1'($urandom_range(0, 1));
                    send(rx, ry, rsx, rsy, ras, model(rx, ry, rsx, rsy, ras));
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                end
                in_valid  = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain("drain_random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
